// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - parametrised single-clock FIFO with programmable almost-full/almost-empty
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through read; default is registered read.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W = ($clog2(FIFO_DEPTH) < 1) ? 1 : $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);
  assign wr_acc      = wr_en & ~full;
  assign rd_acc      = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - scoreboard bench for sync_fifo_prog at depths 8 and 6
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  af_thresh = 4'd8;
  logic [3:0]  ae_thresh = 4'd0;
  logic [2:0]  af6 = 3'd4;
  logic [2:0]  ae6 = 3'd1;

  logic [15:0] data_out, data_out6;
  logic        rd_valid, wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic        rd_valid6, wr_ack6, overflow6, underflow6, full6, empty6, almostfull6, almostempty6;
  logic [3:0]  count;
  logic [2:0]  count6;

  int n_checks = 0;
  int n_errs   = 0;

  logic [15:0] m8[$];
  logic [15:0] m6[$];
  logic [15:0] e8[$];
  logic [15:0] e6[$];
  bit exp_ack8, exp_ovf8, exp_udf8, exp_rv8;
  bit exp_ack6, exp_ovf6, exp_udf6, exp_rv6;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(data_out),
    .rd_valid(rd_valid), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .count(count)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .af_thresh(af6), .ae_thresh(ae6), .data_out(data_out6),
    .rd_valid(rd_valid6), .wr_ack(wr_ack6), .overflow(overflow6), .underflow(underflow6),
    .full(full6), .empty(empty6), .almostfull(almostfull6), .almostempty(almostempty6),
    .count(count6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each presented word against the scoreboard.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
`ifdef FIFO_FWFT_EN
      if (m8.size() == 0) chk("d8_spurious_valid", 1, 0);
      else chk("d8_head", data_out, m8[0]);
`else
      if (e8.size() == 0) chk("d8_spurious_valid", 1, 0);
      else chk("d8_data", data_out, e8.pop_front());
`endif
    end
    if (rd_valid6 === 1'b1) begin
`ifdef FIFO_FWFT_EN
      if (m6.size() == 0) chk("d6_spurious_valid", 1, 0);
      else chk("d6_head", data_out6, m6[0]);
`else
      if (e6.size() == 0) chk("d6_spurious_valid", 1, 0);
      else chk("d6_data", data_out6, e6.pop_front());
`endif
    end
  end

  // One clock of stimulus; reference models are plain queues updated at the edge.
  task automatic step(input bit w, input logic [15:0] d, input bit r, input bit rs = 0);
    bit wa, ra;
    wr_en = w; data_in = d; rd_en = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      m8.delete(); e8.delete(); m6.delete(); e6.delete();
      {exp_ack8, exp_ovf8, exp_udf8, exp_rv8} = '0;
      {exp_ack6, exp_ovf6, exp_udf6, exp_rv6} = '0;
    end else begin
      wa = w && (m8.size() < 8);
      ra = r && (m8.size() > 0);
      exp_ack8 = wa; exp_ovf8 = w && !wa; exp_udf8 = r && !ra; exp_rv8 = ra;
      if (ra) e8.push_back(m8.pop_front());
      if (wa) m8.push_back(d);
      wa = w && (m6.size() < 6);
      ra = r && (m6.size() > 0);
      exp_ack6 = wa; exp_ovf6 = w && !wa; exp_udf6 = r && !ra; exp_rv6 = ra;
      if (ra) e6.push_back(m6.pop_front());
      if (wa) m6.push_back(d);
    end
`ifdef FIFO_FWFT_EN
    e8.delete(); e6.delete();
    exp_rv8 = (m8.size() != 0); exp_rv6 = (m6.size() != 0);
`endif
    @(negedge clk);
    chk("count8", count, m8.size());
    chk("full8", full, m8.size() == 8);
    chk("empty8", empty, m8.size() == 0);
    chk("af8", almostfull, m8.size() >= int'(af_thresh));
    chk("ae8", almostempty, m8.size() <= int'(ae_thresh));
    chk("wr_ack8", wr_ack, exp_ack8);
    chk("overflow8", overflow, exp_ovf8);
    chk("underflow8", underflow, exp_udf8);
    chk("rd_valid8", rd_valid, exp_rv8);
    chk("count6", count6, m6.size());
    chk("full6", full6, m6.size() == 6);
    chk("empty6", empty6, m6.size() == 0);
    chk("af6", almostfull6, m6.size() >= int'(af6));
    chk("ae6", almostempty6, m6.size() <= int'(ae6));
    chk("wr_ack6", wr_ack6, exp_ack6);
    chk("overflow6", overflow6, exp_ovf6);
    chk("underflow6", underflow6, exp_udf6);
    chk("rd_valid6", rd_valid6, exp_rv6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    // Reset wins over simultaneous requests.
    step(1, 16'hdead, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0);
`ifndef FIFO_FWFT_EN
    chk("reset_data_out", data_out, 16'h0000);
`endif

    for (int i = 1; i <= 9; i++) step(1, 16'(i), 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1);

    af_thresh = 4'd6; ae_thresh = 4'd2;
    for (int i = 0; i < 6; i++) step(1, 16'h0100 + 16'(i), 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // Half fill then stream through both depths' wrap points.
    for (int i = 0; i < 3; i++) step(1, 16'h0200 + 16'(i), 0);
    for (int i = 0; i < 20; i++) step(1, 16'h0300 + 16'(i), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // Full with simultaneous write/read, then mid-stream reset.
    for (int i = 0; i < 8; i++) step(1, 16'h0400 + 16'(i), 0);
    step(1, 16'h04ff, 1);
    step(1, 16'h0500, 1);
    step(1, 16'h0501, 0, 1);
    step(0, 0, 0);
    step(1, 16'h0600, 1);

    for (int i = 0; i < 400; i++) begin
      af_thresh = 4'($urandom_range(0, 8));
      ae_thresh = 4'($urandom_range(0, 8));
      step($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 63) == 0);
    end
    while (m8.size() != 0 || m6.size() != 0) step(0, 0, 1);
    step(0, 0, 0);
    chk("sb8_drained", e8.size(), 0);
    chk("sb6_drained", e6.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
